// File: rtl/lane_dual_sram_pkg.sv
// -----------------------------------------------------------------------------
// lane_dual_sram_pkg
// Shared types and helpers for the lane-masked dual-port SRAM.
//   clr_state_e : clear engine states (ST_IDLE, ST_CLEAR)
//   lane_mask() : expands a per-lane enable vector into a per-bit mask.
//                 Used by the write path and by the optional bypass merge
//                 (LANE_DUAL_SRAM_BYPASS_EN) in the top level.
// -----------------------------------------------------------------------------
package lane_dual_sram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // Upper bounds for the helper's argument/result widths. Callers cast
    // their own vectors in and the result back down to DATA_WIDTH.
    localparam int MAX_DATA_WIDTH = 256;
    localparam int MAX_LANES      = 256;

    // Bit i of the result copies the enable of the lane that owns bit i.
    function automatic logic [MAX_DATA_WIDTH-1:0] lane_mask(
        input logic [MAX_LANES-1:0] mask,
        input int                   lane_width
    );
        logic [MAX_DATA_WIDTH-1:0] bits;
        bits = '0;
        for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
            bits[i] = mask[i / lane_width];
        end
        return bits;
    endfunction

endpackage

// File: rtl/sram_clear_ctrl.sv
// -----------------------------------------------------------------------------
// sram_clear_ctrl
// Sequential row-by-row clear engine for lane_dual_sram.
// Ports:
//   clk, Rst_n   : clock, synchronous active-low reset
//   Mem_Clear    : start pulse, only honoured in ST_IDLE
//   Clear_Busy   : high while in ST_CLEAR (exactly RAM_DEPTH cycles)
//   Clear_Done   : one-cycle pulse in the first ST_IDLE cycle after a clear
//   clr_we       : zero-write strobe for the array this cycle
//   clr_addr     : row being cleared this cycle
//   state        : current FSM state (observation only)
// -----------------------------------------------------------------------------
module sram_clear_ctrl
    import lane_dual_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  Rst_n,
    input  logic                  Mem_Clear,
    output logic                  Clear_Busy,
    output logic                  Clear_Done,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output clr_state_e            state
);

    // One extra bit so RAM_DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] LAST_ROW = (ADDR_WIDTH+1)'(RAM_DEPTH - 1);

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  done_q, done_d;

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        clr_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Mem_Clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                // Mem_Clear is deliberately ignored here: no restart.
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_ROW) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign clr_addr   = cnt_q[ADDR_WIDTH-1:0];
    assign Clear_Busy = (state_q == ST_CLEAR);
    assign Clear_Done = done_q;
    assign state      = state_q;

endmodule

// File: rtl/lane_dual_sram.sv
// -----------------------------------------------------------------------------
// lane_dual_sram
// Simple dual-port SRAM (one write, one read port) with per-lane write mask,
// registered read data/valid and a sequential clear engine.
// Optional feature macro: LANE_DUAL_SRAM_BYPASS_EN
//   defined     : same-cycle read of the address being written returns the
//                 merged (post-write) word
//   not defined : same case returns the pre-write word (read-before-write)
// Ports:
//   clk, Rst_n                 : clock, synchronous active-low reset
//   Chip_Select                : gates both ports
//   En_Write, Write_Mask,
//   Write_Addr, Write_Data     : lane-masked write port
//   En_Read, Read_Addr         : read request
//   Read_Data, Read_Valid      : read result one cycle after the request
//   Mem_Clear                  : clear start pulse
//   Clear_Busy, Clear_Done     : clear engine status
// Read handshake: a request accepted at posedge N (Chip_Select & En_Read,
// engine idle, no clear starting) raises Read_Valid for the cycle after N
// with the word in Read_Data; otherwise Read_Valid=0 and Read_Data=0.
// There is no back-pressure.
// Array contents are not reset.
// -----------------------------------------------------------------------------
module lane_dual_sram
    import lane_dual_sram_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int LANE_WIDTH = 8,
    parameter  int ADDR_WIDTH = 6,
    parameter  int RAM_DEPTH  = 1 << ADDR_WIDTH,
    localparam int LANES      = DATA_WIDTH / LANE_WIDTH
) (
    input  logic                  clk,
    input  logic                  Rst_n,
    input  logic                  Chip_Select,
    input  logic                  En_Write,
    input  logic [LANES-1:0]      Write_Mask,
    input  logic [ADDR_WIDTH-1:0] Write_Addr,
    input  logic [DATA_WIDTH-1:0] Write_Data,
    input  logic                  En_Read,
    input  logic [ADDR_WIDTH-1:0] Read_Addr,
    output logic [DATA_WIDTH-1:0] Read_Data,
    output logic                  Read_Valid,
    input  logic                  Mem_Clear,
    output logic                  Clear_Busy,
    output logic                  Clear_Done
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(RAM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    clr_state_e            state;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    sram_clear_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAM_DEPTH  (RAM_DEPTH)
    ) u_clear_ctrl (
        .clk        (clk),
        .Rst_n      (Rst_n),
        .Mem_Clear  (Mem_Clear),
        .Clear_Busy (Clear_Busy),
        .Clear_Done (Clear_Done),
        .clr_we     (clr_we),
        .clr_addr   (clr_addr),
        .state      (state)
    );

    logic                  req_ok;
    logic                  wr_in_range, rd_in_range;
    logic                  wr_fire, rd_fire;
    logic [DATA_WIDTH-1:0] bit_mask;
    logic [DATA_WIDTH-1:0] wr_old, wr_word;
    logic [DATA_WIDTH-1:0] rd_old, rd_word;

    // A clear request in IDLE wins the cycle: both ports are dropped.
    assign req_ok      = Chip_Select & (state == ST_IDLE) & ~Mem_Clear;
    assign wr_in_range = ({1'b0, Write_Addr} < DEPTH_W);
    assign rd_in_range = ({1'b0, Read_Addr}  < DEPTH_W);
    assign wr_fire     = req_ok & En_Write & wr_in_range;
    assign rd_fire     = req_ok & En_Read;

    assign bit_mask = DATA_WIDTH'(lane_mask(MAX_LANES'(Write_Mask), LANE_WIDTH));

    assign wr_old  = wr_in_range ? mem[Write_Addr] : '0;
    assign wr_word = (wr_old & ~bit_mask) | (Write_Data & bit_mask);
    // Out-of-range reads are still valid, they just return zero.
    assign rd_old  = rd_in_range ? mem[Read_Addr] : '0;

`ifdef LANE_DUAL_SRAM_BYPASS_EN
    assign rd_word = (wr_fire && (Write_Addr == Read_Addr)) ? wr_word : rd_old;
`else
    assign rd_word = rd_old;
`endif

    // Clear strobes and port writes are mutually exclusive (state-gated);
    // nothing is written while reset is asserted, so an aborted clear
    // leaves the not-yet-reached rows intact.
    always_ff @(posedge clk) begin
        if (Rst_n) begin
            if (clr_we) begin
                mem[clr_addr] <= '0;
            end else if (wr_fire) begin
                mem[Write_Addr] <= wr_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            Read_Valid <= 1'b0;
            Read_Data  <= '0;
        end else begin
            Read_Valid <= rd_fire;
            Read_Data  <= rd_fire ? rd_word : '0;
        end
    end

endmodule
